gate_tt_checker: RTL
====================

// Module: gate_tt_checker
// PURPOSE
//  Self-checking stimulus/response stage wrapped around a combinational N-input gate.
//  Upstream of the gate, it drives every input combination on a_out. Downstream of the
//  gate, it samples the gate output on c_in and checks it against a parameterised truth table.
//  Replaces hand-written #delay stimulus with a clocked, synthesizable sweep that reports pass/fail.
// PARAMETERS
//  N_IN    2        number of gate inputs; sweep length 2**N_IN vectors
//  SETTLE  1        cycles a_out is held before sampling; legal range >= 1
//  EXP     4'b1000  expected truth table, width 2**N_IN; EXP[i] = expected c for a_out==i (default = AND)
// PORTS
//  clk      in   1         rising-edge clock
//  rst      in   1         synchronous, active-high reset
//  start    in   1         begin a sweep; sampled only in IDLE or DONE
//  a_out    out  N_IN      gate input vector; bit 0 -> gate input a, bit 1 -> b
//  c_in     in   1         gate output under test
//  busy     out  1         high in DRIVE/SAMPLE
//  done     out  1         high in DONE; held until next start or rst
//  pass     out  1         done && err_cnt==0
//  err_cnt  out  N_IN+1    mismatch count for current/last sweep, saturates at 2**N_IN
//  vec_idx  out  N_IN      index of the vector currently driven (equals a_out)
// BEHAVIOUR
//  Reset: state=IDLE; a_out, vec_idx, err_cnt, busy, done, pass = 0. Reset mid-sweep aborts immediately, with no partial result.
//  FSM IDLE -> DRIVE on start. DONE -> DRIVE on start (restart). All other start pulses are ignored.
//  Entering DRIVE from IDLE/DONE: vec_idx=0, err_cnt=0, settle cnt=0, done=0.
//  DRIVE: a_out=vec_idx; cnt increments each cycle; at cnt==SETTLE-1 go to SAMPLE. DRIVE lasts exactly SETTLE cycles.
//  SAMPLE (1 cycle): a_out is unchanged. At the closing edge, if c_in!=EXP[vec_idx] then err_cnt+=1.
//   If vec_idx==2**N_IN-1, go to DONE. Otherwise vec_idx+=1, cnt=0, and go to DRIVE. vec_idx does not wrap.
//  DONE: a_out holds the last vector; done=1; pass is registered with done.
//  Latency: done rises 2**N_IN*(SETTLE+1)+1 edges after the edge that samples start. Default = 9.
//  c_in is sampled only in SAMPLE; c_in is don't-care in every other state.
//  Width rule: err_cnt is N_IN+1 bits, so the all-fail count 2**N_IN fits without overflow.
//  start and rst high on the same edge: rst wins.
// CONFIGURATION
//  Macro GATE_TT_FIRST_FAIL_EN.
//   Defined: adds ports fail_vld (out,1) and fail_idx (out,N_IN). On the first mismatch of a sweep,
//    fail_idx is set to vec_idx and fail_vld to 1. Both hold through DONE.
//    Both clear on rst and on sweep start.
//   Undefined: these ports and their registers do not exist. All other behaviour is identical.
// STRUCTURE
//  Package gate_tt_pkg: state typedef (IDLE, DRIVE, SAMPLE, DONE) and default SETTLE/EXP localparams.
//  Sub-module settle_timer: counts 0..SETTLE-1 with clear/enable inputs and a terminal-count output.
//   Instantiated once.
//  Top: FSM, vec_idx/err_cnt registers, compare logic, optional first-fail capture.
// TESTING
//  1. N_IN=2, SETTLE=1, EXP=4'b1000, 2-input AND gate model, start pulse at cycle 0
//     -> a_out steps 0,1,2,3; done at cycle 9; err_cnt=0; pass=1.
//  2. Same setup with c_in tied to 0 (stuck-at-0)
//     -> err_cnt=1, pass=0. With macro: fail_vld=1, fail_idx=3.
//  3. c_in tied to 1
//     -> err_cnt=3. With macro: fail_idx=0, and it is not overwritten by later mismatches.
//  4. SETTLE=3, AND gate model
//     -> each vector is held 4 cycles; done at cycle 17; pass=1.
//  5. Pulse start again during DRIVE of vector 1
//     -> ignored; sweep completes normally at cycle 9.
//     Then pulse start in DONE -> done drops next edge, err_cnt=0, vec_idx=0.
//  6. Assert rst in SAMPLE of vector 2 with err_cnt=1
//     -> next edge: IDLE, all outputs 0. A fresh start completes with pass=1.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg
//   Shared definitions for the gate truth-table checker.
//   - state_e     : sweep FSM states (IDLE, DRIVE, SAMPLE, DONE)
//   - SETTLE_DEF  : default number of cycles each vector is held before sampling
//   - EXP_DEF     : default expected truth table (2-input AND)
package gate_tt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        DONE
    } state_e;

    localparam int unsigned SETTLE_DEF = 1;
    localparam logic [3:0]  EXP_DEF    = 4'b1000;

endpackage

// File: rtl/settle_timer.sv
// settle_timer
//   Counts 0..SETTLE-1 while enabled and wraps to 0 after the terminal count.
//   Ports:
//     clk_i  in   rising-edge clock
//     rst_i  in   synchronous active-high reset
//     clr_i  in   force the count to 0 (has priority over en_i)
//     en_i   in   advance the count
//     tc_o   out  count is at SETTLE-1
module settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == CW'(SETTLE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//   Drives every input combination of an N_IN-input combinational gate on a_out,
//   holds each vector SETTLE cycles, samples the gate output on c_in for one cycle
//   and compares it with the truth table EXP.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous active-high reset (wins over start)
//     start    in   begin a sweep; honoured only in IDLE or DONE
//     a_out    out  vector applied to the gate (bit 0 -> input a)
//     c_in     in   gate output under test; looked at only in SAMPLE
//     busy     out  sweep in progress (DRIVE/SAMPLE)
//     done     out  sweep finished; held until next start or rst
//     pass     out  done with zero mismatches
//     err_cnt  out  mismatch count, saturates at 2**N_IN
//     vec_idx  out  index of the vector being driven
//   Optional feature, macro GATE_TT_FIRST_FAIL_EN:
//     fail_vld out  a mismatch has occurred in this sweep
//     fail_idx out  vector index of the first mismatch
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int unsigned               N_IN   = 2,
    parameter int unsigned               SETTLE = SETTLE_DEF,
    parameter logic [(2**N_IN)-1:0]      EXP    = EXP_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] a_out,
    input  logic            c_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] vec_idx
`ifdef GATE_TT_FIRST_FAIL_EN
    ,
    output logic            fail_vld,
    output logic [N_IN-1:0] fail_idx
`endif
);

    localparam int unsigned NV = 2**N_IN;

    state_e          state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic [N_IN:0]   err_q, err_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            tc;
    logic            mismatch;
    logic            restart;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (state_q != DRIVE),
        .en_i  (state_q == DRIVE),
        .tc_o  (tc)
    );

    assign restart  = start && ((state_q == IDLE) || (state_q == DONE));
    assign mismatch = (state_q == SAMPLE) && (c_in != EXP[vec_q]);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        err_d   = err_q;
        done_d  = done_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (restart) begin
                    state_d = DRIVE;
                    vec_d   = '0;
                    err_d   = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (state_q == DONE) begin
                    // done/pass are registered from the DONE state, so they
                    // rise one edge after the final sample has been counted.
                    done_d = 1'b1;
                    pass_d = (err_q == '0);
                end
            end
            DRIVE: begin
                if (tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch && (err_q != (N_IN + 1)'(NV))) begin
                    err_d = err_q + 1'b1;
                end
                if (vec_q == N_IN'(NV - 1)) begin
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

`ifdef GATE_TT_FIRST_FAIL_EN
    logic            ffv_q, ffv_d;
    logic [N_IN-1:0] ffi_q, ffi_d;

    always_comb begin
        ffv_d = ffv_q;
        ffi_d = ffi_q;
        if (restart) begin
            ffv_d = 1'b0;
            ffi_d = '0;
        end else if (mismatch && !ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = vec_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ffv_q <= 1'b0;
            ffi_q <= '0;
        end else begin
            ffv_q <= ffv_d;
            ffi_q <= ffi_d;
        end
    end

    assign fail_vld = ffv_q;
    assign fail_idx = ffi_q;
`endif

    assign a_out   = vec_q;
    assign vec_idx = vec_q;
    assign err_cnt = err_q;
    assign busy    = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done    = done_q;
    assign pass    = pass_q;

endmodule
